// File: rtl/fifo_read_switch.sv
// Counted transfer from an upstream FIFO into a 2-entry first-word-fall-through
// buffer read by a downstream consumer; done pulses once the last word is taken.
module fifo_read_switch #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic [DATA_WIDTH-1:0] fifo_i_dout,
   input  logic                  fifo_i_empty_n,
   output logic                  fifo_i_read,
   output logic [DATA_WIDTH-1:0] fifo_o_dout,
   output logic                  fifo_o_empty_n,
   input  logic                  fifo_o_read,
   input  logic                  fifo_en,
   input  logic                  start,
   input  logic [CNT_WIDTH-1:0]  count,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_WIDTH-1:0]  xfer_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                state;
   logic [1:0]            occ;
   logic [DATA_WIDTH-1:0] buf0, buf1;
   logic [CNT_WIDTH-1:0]  fetch_rem;
   logic                  push, pop;

   // Fetch gating uses registered occupancy only, so a consumer pop never
   // reaches fifo_i_read combinationally; a full buffer costs one bubble.
   assign fifo_i_read    = (state == RUN) & fifo_en & fifo_i_empty_n &
                           (occ != 2'd2) & (fetch_rem != '0);
   assign push           = fifo_i_read;
   assign pop            = fifo_o_read & (occ != 2'd0);
   assign fifo_o_dout    = buf0;
   assign fifo_o_empty_n = (occ != 2'd0);
   assign busy           = (state != IDLE);

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state     <= IDLE;
         occ       <= 2'd0;
         buf0      <= '0;
         buf1      <= '0;
         fetch_rem <= '0;
         xfer_cnt  <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         occ  <= occ + {1'b0, push} - {1'b0, pop};

         // buf0 is always the head; a push lands wherever the head will be after a pop
         if (push && (occ == 2'd0 || (occ == 2'd1 && pop)))
            buf0 <= fifo_i_dout;
         else if (pop)
            buf0 <= buf1;
         if (push && ((occ == 2'd1 && !pop) || occ == 2'd2))
            buf1 <= fifo_i_dout;

         if (pop)  xfer_cnt  <= xfer_cnt + 1'b1;
         if (push) fetch_rem <= fetch_rem - 1'b1;

         case (state)
            IDLE: begin
               if (start) begin
                  xfer_cnt <= '0;
                  if (count != '0) begin
                     fetch_rem <= count;
                     state     <= RUN;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (fetch_rem == '0) state <= DRAIN;
            end
            DRAIN: begin
               if (occ == 2'd0 && !push) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/fifo_read_switch.md
FIFO_READ_SWITCH -- requirements
Module: fifo_read_switch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width of both FIFO ports.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of count and xfer_cnt.
REQ-003 SHALL have port ap_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port ap_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port fifo_i_dout  input  DATA_WIDTH  upstream FIFO head word, valid while fifo_i_empty_n=1.
REQ-006 SHALL have port fifo_i_empty_n  input  1  upstream FIFO holds at least one word.
REQ-007 SHALL have port fifo_i_read  output  1  pops upstream word in the same cycle.
REQ-008 SHALL have port fifo_o_dout  output  DATA_WIDTH  head word presented to consumer.
REQ-009 SHALL have port fifo_o_empty_n  output  1  internal buffer holds at least one word.
REQ-010 SHALL have port fifo_o_read  input  1  consumer pop request.
REQ-011 SHALL have port fifo_en  input  1  level enable for upstream fetching.
REQ-012 SHALL have port start  input  1  single-cycle transfer request.
REQ-013 SHALL have port count  input  CNT_WIDTH  word count, sampled with start.
REQ-014 SHALL have port busy  output  1  high in RUN or DRAIN.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port xfer_cnt  output  CNT_WIDTH  words delivered to consumer in current/last transfer.

Function
REQ-017 SHALL contain a 2-entry registered FIFO buffer (occupancy 0..2), first-word-fall-through: fifo_o_dout = oldest entry, fifo_o_empty_n = (occ!=0).
REQ-018 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-019 SHALL, in IDLE on start=1 with count!=0, load fetch_rem=count, clear xfer_cnt to 0, go to RUN next cycle.
REQ-020 SHALL, in IDLE on start=1 with count=0, clear xfer_cnt, pulse done the next cycle, remain IDLE.
REQ-021 SHALL ignore start while busy=1.
REQ-022 SHALL drive fifo_i_read = (state==RUN) & fifo_en & fifo_i_empty_n & (occ<2) & (fetch_rem!=0), using registered occ only (no combinational path from fifo_o_read to fifo_i_read).
REQ-023 SHALL, on fifo_i_read=1, write fifo_i_dout into the buffer and decrement fetch_rem; word visible on fifo_o_dout with fifo_o_empty_n=1 in the following cycle (latency 1).
REQ-024 SHALL go RUN->DRAIN in the cycle after fetch_rem reaches 0.
REQ-025 SHALL pop the buffer and increment xfer_cnt when fifo_o_read=1 and fifo_o_empty_n=1; fifo_o_read while empty SHALL be ignored.
REQ-026 SHALL allow simultaneous push and pop in one cycle (occ unchanged, order preserved).
REQ-027 SHALL go DRAIN->IDLE and pulse done for exactly one cycle when occ=0 and no push pending.
REQ-028 SHALL, with fifo_en=0 in RUN, stop fetching but continue serving consumer pops; fetching resumes when fifo_en returns to 1.
REQ-029 SHALL never issue fifo_i_read outside RUN, never fetch more than count words per transfer.
REQ-030 SHALL wrap nothing: xfer_cnt holds final value in IDLE until next accepted start.

Reset
REQ-031 SHALL, on ap_rst_n=0 (any time, including mid-transfer), immediately force state=IDLE, occ=0, fetch_rem=0, xfer_cnt=0, busy=0, done=0, fifo_i_read=0, fifo_o_empty_n=0; fifo_o_dout SHALL reset to 0; buffered words are discarded.
REQ-032 SHALL resume normal operation on the first rising edge after ap_rst_n deasserts.

Verification
REQ-033 SHALL verify: start,count=4, upstream always non-empty with 0xA0..0xA3, consumer fifo_o_read=1 -> four words in order, xfer_cnt=4, one done pulse, exactly 4 fifo_i_read cycles.
REQ-034 SHALL verify: count=3, consumer fifo_o_read=0 for 10 cycles -> fifo_i_read stops after 2 words (occ=2), then resumes on pops; total 3 upstream reads.
REQ-035 SHALL verify: count=5, fifo_en=0 after 2 fetches for 6 cycles -> no fifo_i_read while low, buffer drains, transfer completes with xfer_cnt=5 after fifo_en=1.
REQ-036 SHALL verify: start with count=0 -> done pulse next cycle, busy stays 0, no fifo_i_read; second start during RUN -> ignored.
REQ-037 SHALL verify: ap_rst_n low mid-RUN with occ=2 -> outputs at reset values same cycle, fifo_o_empty_n=0; new start,count=1 after release completes normally.
